// File: rtl/vga_draw_requester.sv
// vga_draw_requester
//
// Keeps a 12x12 grid of step bits and turns each "toggle" request into one
// block draw on the display side. Requests are queued in a small FIFO, so
// bursts of toggles can arrive while the display is still busy. Each popped
// request inverts its bit and issues a one-cycle draw_enable with the block
// position and new colour.
//
// Parameters
//   X0, Y0      grid origin in pixels
//   PITCH       cell-to-cell spacing in pixels
//   FIFO_DEPTH  toggle queue depth (power of 2, at least 2)
//
// Ports
//   CLOCK_50     sole clock, rising edge
//   nReset       asynchronous active-low reset
//   toggle       one-cycle request to invert cell (cell_row, cell_col)
//   cell_row     target row, 0..11
//   cell_col     target column, 0..11
//   rd_row       combinational read row select
//   drawing      display busy flag
//   draw_enable  one-cycle draw start pulse
//   X, Y         block top-left position
//   state        block colour: 1 = on/white, 0 = off/blue
//   rd_bits      step bits of row rd_row (bit c = column c), 0 for rows > 11
//   busy         FSM not idle or FIFO not empty
//   overflow     sticky: an in-range toggle was dropped on a full FIFO
module vga_draw_requester #(
    parameter logic [9:0]  X0         = 10'd214,
    parameter logic [8:0]  Y0         = 9'd32,
    parameter int unsigned PITCH      = 33,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLOCK_50,
    input  logic        nReset,
    input  logic        toggle,
    input  logic [3:0]  cell_row,
    input  logic [3:0]  cell_col,
    input  logic [3:0]  rd_row,
    input  logic        drawing,
    output logic        draw_enable,
    output logic [9:0]  X,
    output logic [8:0]  Y,
    output logic        state,
    output logic [11:0] rd_bits,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned GRID = 12;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);
    // WAIT_HI lasts this many + 1 cycles before the pulse is repeated
    localparam logic [3:0]  WaitHiLast = 4'd15;

    typedef enum logic [2:0] {
        StWaitInit,
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo,
        StGap
    } fsm_e;

    fsm_e          fsm_q;
    logic          seen_hi_q;
    logic [3:0]    wait_cnt_q;
    logic [11:0]   bits_q [GRID];

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx_q;
    logic [AW-1:0] rd_idx_q;
    logic [AW:0]   count_q;

    logic          in_range;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [3:0]    head_row;
    logic [3:0]    head_col;
    logic [9:0]    col_pitch;
    logic [9:0]    row_pitch;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign in_range   = (cell_row < 4'd12) && (cell_col < 4'd12);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign pop        = (fsm_q == StIdle) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push       = toggle && in_range && (!fifo_full || pop);

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_idx_q <= wr_idx_q + 1'b1;
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (toggle && in_range && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Queue payload needs no reset; occupancy is tracked by count_q
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_idx_q] <= {cell_row, cell_col};
        end
    end

    assign {head_row, head_col} = fifo_mem[rd_idx_q];

    // Products kept 10 bits wide so 11 * PITCH cannot truncate
    assign col_pitch = 10'(head_col) * 10'(PITCH);
    assign row_pitch = 10'(head_row) * 10'(PITCH);

    // ------------------------------------------------------------------
    // Status and read port
    // ------------------------------------------------------------------
    assign busy = (fsm_q != StIdle) || !fifo_empty;

    always_comb begin
        rd_bits = '0;
        if (rd_row < 4'd12) begin
            rd_bits = bits_q[rd_row];
        end
    end

    // ------------------------------------------------------------------
    // Draw sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            fsm_q       <= StWaitInit;
            seen_hi_q   <= 1'b0;
            wait_cnt_q  <= '0;
            draw_enable <= 1'b0;
            X           <= X0;
            Y           <= Y0;
            state       <= 1'b0;
            for (int r = 0; r < GRID; r++) begin
                bits_q[r] <= '0;
            end
        end else begin
            // draw_enable is set only on entry to StIssue, so it is high
            // for exactly the StIssue cycle
            draw_enable <= 1'b0;
            unique case (fsm_q)
                StWaitInit: begin
                    // The display wipes the grid after power-up; wait for
                    // that draw to start and finish before issuing our own
                    if (drawing) begin
                        seen_hi_q <= 1'b1;
                    end else if (seen_hi_q) begin
                        fsm_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (pop) begin
                        bits_q[head_row][head_col] <= ~bits_q[head_row][head_col];
                        state       <= ~bits_q[head_row][head_col];
                        X           <= X0 + col_pitch;
                        Y           <= 9'(10'(Y0) + row_pitch);
                        draw_enable <= 1'b1;
                        fsm_q       <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt_q <= '0;
                    fsm_q      <= StWaitHi;
                end
                StWaitHi: begin
                    if (drawing) begin
                        fsm_q <= StWaitLo;
                    end else if (wait_cnt_q == WaitHiLast) begin
                        // Display missed the pulse: repeat it, same X/Y/state
                        draw_enable <= 1'b1;
                        fsm_q       <= StIssue;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StWaitLo: begin
                    if (!drawing) begin
                        fsm_q <= StGap;
                    end
                end
                StGap: begin
                    // Lets the display settle into idle before the next pulse
                    fsm_q <= StIdle;
                end
                default: begin
                    fsm_q <= StWaitInit;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_draw_requester.md
VGA_DRAW_REQUESTER -- requirements
Module: vga_draw_requester

Interface
REQ-001 SHALL have parameter X0, default 10'd214, meaning the grid origin x pixel.
REQ-002 SHALL have parameter Y0, default 9'd32, meaning the grid origin y pixel.
REQ-003 SHALL have parameter PITCH, default 33, meaning the cell-to-cell pixel spacing.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the toggle queue depth (power of 2).
REQ-005 CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-006 nReset  input  1  reset, asynchronous, active-low.
REQ-007 toggle  input  1  one-cycle request to invert cell (cell_row, cell_col).
REQ-008 cell_row  input  4  target row, valid 0..11.
REQ-009 cell_col  input  4  target column, valid 0..11.
REQ-010 rd_row  input  4  combinational read row select.
REQ-011 drawing  input  1  display-side busy flag.
REQ-012 draw_enable  output  1  one-cycle draw start pulse to the display.
REQ-013 X  output  10  block top-left x.
REQ-014 Y  output  9  block top-left y.
REQ-015 state  output  1  block colour: 1 = white/on, 0 = blue/off.
REQ-016 rd_bits  output  12  step bits of row rd_row; bit c = column c.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-018 overflow  output  1  sticky: a toggle was dropped.

Function
REQ-019 SHALL hold a 12x12 step-bit array; rd_bits SHALL be combinational; rd_row > 11 SHALL give 12'h000.
REQ-020 SHALL enqueue {row, col} on toggle when both are <= 11 and the FIFO is not full; an out-of-range toggle SHALL be ignored without setting overflow.
REQ-021 A toggle arriving when the FIFO is full with no pop in the same cycle SHALL be dropped and SHALL set overflow; a simultaneous push and pop when full SHALL be accepted.
REQ-022 FSM states SHALL be WAIT_INIT, IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP; encoding is free.
REQ-023 WAIT_INIT: wait until drawing has been seen high and then low (the display power-up grid wipe), then go to IDLE; toggles SHALL still be queued in this state.
REQ-024 IDLE, FIFO non-empty: pop the head entry, invert that array bit, and register:
- X = X0 + col*PITCH
- Y = Y0 + row*PITCH
- state = the new bit value
Then go to ISSUE.
REQ-025 ISSUE: draw_enable = 1 for exactly this one cycle; go to WAIT_HI.
REQ-026 WAIT_HI: on drawing = 1 go to WAIT_LO; after 16 cycles without drawing high, return to ISSUE (re-pulse) with X/Y/state unchanged.
REQ-027 WAIT_LO: on drawing = 0 go to GAP.
REQ-028 GAP: one idle cycle, then IDLE; this guarantees the display is back in its idle state before the next pulse.
REQ-029 X, Y and state SHALL stay stable from ISSUE through GAP.
REQ-030 draw_enable SHALL be 0 in every state other than ISSUE.
REQ-031 Latency: toggle sampled at edge E0 with FIFO empty and FSM in IDLE -> pop at E1 -> draw_enable high between E1 and E2.
REQ-032 Repeated toggles of the same cell SHALL be processed in order, one draw each, each draw using the bit value after that toggle.
REQ-033 Arithmetic: col*PITCH and row*PITCH SHALL be computed at least 10 bits wide; the maximum values (X = 577, Y = 395) SHALL not truncate.

Reset
REQ-034 On nReset low, at any time and including mid-draw, the following SHALL take effect immediately:
- all step bits = 0, FIFO empty, FSM = WAIT_INIT
- draw_enable = 0, X = X0, Y = Y0, state = 0
- overflow = 0, busy = 1
REQ-035 After reset release, no draw_enable SHALL occur before the WAIT_INIT condition is met.

Verification
REQ-036 Reset, drawing pulsed high 100 cycles then low, then toggle (row 0, col 0) -> one draw_enable pulse, X = 214, Y = 32, state = 1, rd_bits(row 0) = 12'h001.
REQ-037 Toggle (row 11, col 11) twice back-to-back -> two pulses, both with X = 577, Y = 395; first state = 1, second state = 0; final bit = 0.
REQ-038 Hold drawing high for a long time, issue 6 toggles -> first 5 accepted (4 queued, 1 popped), 6th dropped, overflow = 1 and stays 1.
REQ-039 Toggle with cell_col = 12 -> no enqueue, no draw, overflow unchanged.
REQ-040 drawing held low after draw_enable -> draw_enable re-pulses after 16 cycles with identical X/Y/state.
REQ-041 Assert nReset low during WAIT_LO -> draw_enable = 0, all rd_bits = 0, FSM waits for a new init sequence.
